// File: rtl/phase_seq_timer.sv
// Phase sequencer: steps a phase index through a programmable table of per-phase
// durations (seconds), using a prescaler to derive the 1 s tick. Optional skip input under PHASE_SKIP_EN.
module phase_seq_timer #(
  parameter int PRESCALE     = 10000,
  parameter int SEC_W        = 16,
  parameter int NUM_PHASES   = 4,
  parameter int PH_W         = 2,
  parameter int DEFAULT_SECS = 5
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
`ifdef PHASE_SKIP_EN
  input  logic             skip,
`endif
  input  logic             cfg_we,
  input  logic [PH_W-1:0]  cfg_idx,
  input  logic [SEC_W-1:0] cfg_secs,
  output logic [PH_W-1:0]  phase,
  output logic [SEC_W-1:0] remaining,
  output logic             phase_done,
  output logic             cycle_done,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(NUM_PHASES - 1);
  localparam logic [SEC_W-1:0] DEF     = SEC_W'(DEFAULT_SECS);
  localparam logic [SEC_W-1:0] ONE     = SEC_W'(1);

  // Zero durations are clamped to one second so no phase is ever skipped.
  function automatic logic [SEC_W-1:0] eff(input logic [SEC_W-1:0] x);
    return (x == '0) ? ONE : x;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic             pd_q, pd_d;
  logic             cd_q, cd_d;
  logic             busy_q, busy_d;
  logic [SEC_W-1:0] tbl_q [NUM_PHASES];
  logic [SEC_W-1:0] tbl_d [NUM_PHASES];

  logic             skip_w;
  logic [PH_W-1:0]  phase_nxt;
  logic             tick;
  logic             end_now;

`ifdef PHASE_SKIP_EN
  assign skip_w = skip;
`else
  assign skip_w = 1'b0;
`endif

  assign phase_nxt = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
  assign tick      = enable && (presc_q == PS_LAST);
  assign end_now   = ((state_q == S_RUN) && skip_w) || (tick && (rem_q <= ONE));

  // Table writes land on the edge; a phase end on the same edge reads the old entry.
  always_comb begin
    for (int i = 0; i < NUM_PHASES; i++) tbl_d[i] = tbl_q[i];
    if (cfg_we && ({{(32-PH_W){1'b0}}, cfg_idx} < 32'(NUM_PHASES)))
      tbl_d[cfg_idx] = cfg_secs;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    busy_d  = busy_q;
    pd_d    = 1'b0;
    cd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          phase_d = '0;
          rem_d   = eff(tbl_q[0]);
          presc_d = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN, S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
          phase_d = '0;
          rem_d   = '0;
          presc_d = '0;
          busy_d  = 1'b0;
        end else begin
          // Leaving HOLD counts on the same edge, so a pause adds exactly its own length.
          state_d = enable ? S_RUN : S_HOLD;
          if (end_now) begin
            phase_d = phase_nxt;
            rem_d   = eff(tbl_q[phase_nxt]);
            presc_d = '0;
            pd_d    = 1'b1;
            cd_d    = (phase_q == PH_LAST);
          end else if (enable) begin
            if (presc_q == PS_LAST) begin
              presc_d = '0;
              rem_d   = rem_q - ONE;
            end else begin
              presc_d = presc_q + PS_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        rem_d   = '0;
        presc_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      rem_q   <= '0;
      presc_q <= '0;
      pd_q    <= 1'b0;
      cd_q    <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) tbl_q[i] <= DEF;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      pd_q    <= pd_d;
      cd_q    <= cd_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NUM_PHASES; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  assign phase      = phase_q;
  assign remaining  = rem_q;
  assign phase_done = pd_q;
  assign cycle_done = cd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_phase_seq_timer.sv
// Directed bench for phase_seq_timer with PRESCALE=4: vector table for the opening
// cycles, then hand sequences for phase lengths, hold, live writes, stop and reset.
module tb_phase_seq_timer;
  localparam int PS = 4;

  logic        CLK = 1'b0;
  logic        reset, start, stop, enable, cfg_we;
  logic [1:0]  cfg_idx;
  logic [15:0] cfg_secs;
  logic [1:0]  phase;
  logic [15:0] remaining;
  logic        phase_done, cycle_done, busy;
`ifdef PHASE_SKIP_EN
  logic        skip;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  phase_seq_timer #(.PRESCALE(PS), .SEC_W(16), .NUM_PHASES(4), .PH_W(2), .DEFAULT_SECS(5)) dut (
    .CLK(CLK), .reset(reset), .start(start), .stop(stop), .enable(enable),
`ifdef PHASE_SKIP_EN
    .skip(skip),
`endif
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_secs(cfg_secs),
    .phase(phase), .remaining(remaining), .phase_done(phase_done),
    .cycle_done(cycle_done), .busy(busy)
  );

  typedef struct {
    logic        st, sp, en, we;
    logic [1:0]  idx;
    logic [15:0] secs;
    logic [1:0]  ph;
    logic [15:0] rem;
    logic        pd, cd, bz;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(input int st, sp, en, we, idx, secs, ph, rem, pd, cd, bz);
    vec_t v;
    v.st = st[0]; v.sp = sp[0]; v.en = en[0]; v.we = we[0];
    v.idx = idx[1:0]; v.secs = secs[15:0];
    v.ph = ph[1:0]; v.rem = rem[15:0]; v.pd = pd[0]; v.cd = cd[0]; v.bz = bz[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs until phase_done (bounded), then checks length, new phase, reload and cycle_done.
  task automatic wait_pd(input string nm, input int exp_n, input int exp_ph,
                         input int exp_rem, input logic exp_cd);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 200) begin
      step();
      n++;
      seen = phase_done;
    end
    chk({nm, " len"}, n, exp_n);
    chk({nm, " phase"}, 32'(phase), exp_ph);
    chk({nm, " rem"}, 32'(remaining), exp_rem);
    chk({nm, " cycle_done"}, 32'(cycle_done), 32'(exp_cd));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_secs = '0;
`ifdef PHASE_SKIP_EN
    skip = 1'b0;
`endif
    step(); step();
    reset = 1'b0;
    chk("rst phase", 32'(phase), 0);
    chk("rst rem", 32'(remaining), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst pd", 32'(phase_done), 0);
    chk("rst cd", 32'(cycle_done), 0);

    begin
      int bad = 0;
      repeat (50) begin
        step();
        if (phase_done || cycle_done || busy) bad++;
      end
      chk("idle quiet", bad, 0);
    end

    // Default table entry 5 loads on start.
    enable = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("default t0", 32'(remaining), 5);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop to idle", 32'(busy), 0);

    //            st sp en we idx secs  ph rem pd cd bz
    vt[0]  = mk(0, 0, 1, 1, 0, 2,   0, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 1, 1, 1, 3,   0, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 1, 1, 2, 1,   0, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 1, 1, 3, 4,   0, 0, 0, 0, 0);
    vt[4]  = mk(1, 0, 1, 0, 0, 0,   0, 2, 0, 0, 1);
    vt[5]  = mk(1, 0, 1, 0, 0, 0,   0, 2, 0, 0, 1);
    vt[6]  = mk(0, 0, 1, 0, 0, 0,   0, 2, 0, 0, 1);
    vt[7]  = mk(0, 0, 1, 0, 0, 0,   0, 2, 0, 0, 1);
    vt[8]  = mk(0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 1);
    vt[9]  = mk(0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 1);
    vt[10] = mk(0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 1);
    vt[11] = mk(0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 1);
    vt[12] = mk(0, 0, 1, 0, 0, 0,   1, 3, 1, 0, 1);
    vt[13] = mk(0, 0, 1, 0, 0, 0,   1, 3, 0, 0, 1);

    for (int i = 0; i < 14; i++) begin
      start = vt[i].st; stop = vt[i].sp; enable = vt[i].en;
      cfg_we = vt[i].we; cfg_idx = vt[i].idx; cfg_secs = vt[i].secs;
      step();
      chk($sformatf("vec%0d phase", i), 32'(phase), 32'(vt[i].ph));
      chk($sformatf("vec%0d rem", i), 32'(remaining), 32'(vt[i].rem));
      chk($sformatf("vec%0d pd", i), 32'(phase_done), 32'(vt[i].pd));
      chk($sformatf("vec%0d cd", i), 32'(cycle_done), 32'(vt[i].cd));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].bz));
    end
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0; enable = 1'b1;

    // Remaining phases of the first pass: 12 total for phase 1, then 4, 16.
    wait_pd("ph1", 11, 2, 1, 1'b0);
    wait_pd("ph2", 4, 3, 4, 1'b0);
    wait_pd("ph3", 16, 0, 2, 1'b1);
    wait_pd("ph0", 8, 1, 3, 1'b0);

    // Hold for 10 cycles mid-phase 1.
    repeat (5) step();
    enable = 1'b0;
    repeat (10) step();
    chk("hold phase", 32'(phase), 1);
    chk("hold rem", 32'(remaining), 2);
    chk("hold busy", 32'(busy), 1);
    enable = 1'b1;
    wait_pd("ph1 resume", 7, 2, 1, 1'b0);

    // Zero entry for phase 2 while phase 2 is running.
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_secs = 16'd0; step(); cfg_we = 1'b0;
    chk("zero wr rem", 32'(remaining), 1);
    wait_pd("ph2b", 3, 3, 4, 1'b0);
    wait_pd("ph3b", 16, 0, 2, 1'b1);
    wait_pd("ph0b", 8, 1, 3, 1'b0);

    // Live write to the current phase leaves remaining alone.
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_secs = 16'd7; step(); cfg_we = 1'b0;
    chk("live wr rem", 32'(remaining), 3);
    wait_pd("ph1c", 11, 2, 1, 1'b0);
    wait_pd("ph2 zero", 4, 3, 4, 1'b0);

    // Stop in phase 3.
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop phase", 32'(phase), 0);
    chk("stop rem", 32'(remaining), 0);
    chk("stop busy", 32'(busy), 0);
    chk("stop pd", 32'({phase_done, cycle_done}), 0);
    repeat (5) step();
    chk("stop stays idle", 32'({busy, phase_done}), 0);

    start = 1'b1; step(); start = 1'b0;
    chk("restart rem", 32'(remaining), 2);
    chk("restart busy", 32'(busy), 1);
    wait_pd("restart ph0", 8, 1, 7, 1'b0);

    // Write to the next phase on the phase-end edge: old entry loads.
    repeat (27) step();
    chk("pre-end pd", 32'(phase_done), 0);
    chk("pre-end rem", 32'(remaining), 1);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_secs = 16'd9; step(); cfg_we = 1'b0;
    chk("same-edge pd", 32'(phase_done), 1);
    chk("same-edge phase", 32'(phase), 2);
    chk("same-edge rem", 32'(remaining), 1);

    // Reset mid-run restores defaults.
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid rst phase", 32'(phase), 0);
    chk("mid rst rem", 32'(remaining), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst pd", 32'(phase_done), 0);
    start = 1'b1; step(); start = 1'b0;
    chk("mid rst t0", 32'(remaining), 5);
    wait_pd("mid rst ph0", 20, 1, 5, 1'b0);

`ifdef PHASE_SKIP_EN
    stop = 1'b1; step(); stop = 1'b0;
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_secs = 16'd2; step();
    cfg_idx = 2'd1; cfg_secs = 16'd3; step(); cfg_we = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("skip pre rem", 32'(remaining), 2);
    skip = 1'b1; step(); skip = 1'b0;
    chk("skip pd", 32'(phase_done), 1);
    chk("skip phase", 32'(phase), 1);
    chk("skip rem", 32'(remaining), 3);
    enable = 1'b0; step();
    skip = 1'b1; step(); skip = 1'b0;
    chk("hold skip pd", 32'(phase_done), 0);
    chk("hold skip phase", 32'(phase), 1);
    chk("hold skip rem", 32'(remaining), 3);
    enable = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/phase_seq_timer.md
Name: phase_seq_timer

Overview:
Parametrised successor to the single-duration state timer. Holds a programmable table of per-phase durations in seconds and steps a phase index through the table, one phase after another. Uses a prescaler to derive the 1 s tick from CLK. Sits between the traffic-light state decoder (which consumes `phase` and `phase_done`) and the configuration logic (which writes durations).

Parameters:
- PRESCALE, 10000, CLK cycles per second tick (10 kHz clock → 1 s).
- SEC_W, 16, width of duration and remaining-seconds values.
- NUM_PHASES, 4, number of phases in the sequence (2..16).
- PH_W, 2, width of phase index; must satisfy 2^PH_W ≥ NUM_PHASES.
- DEFAULT_SECS, 5, reset value of every table entry.

Ports:
- CLK  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins the sequence at phase 0 (honoured only in IDLE).
- stop  in  1  level/pulse; aborts to IDLE.
- enable  in  1  1 = counting, 0 = freeze (hold).
- cfg_we  in  1  table write strobe.
- cfg_idx  in  PH_W  table write index.
- cfg_secs  in  SEC_W  duration to write.
- phase  out  PH_W  current phase index.
- remaining  out  SEC_W  whole seconds left in current phase.
- phase_done  out  1  one-cycle pulse at each phase end.
- cycle_done  out  1  one-cycle pulse when the last phase ends (wrap to 0).
- busy  out  1  high in RUN or HOLD.

Behaviour:
- Reset (synchronous, highest priority):
  - state = IDLE; phase = 0; remaining = 0; prescaler = 0.
  - phase_done = 0; cycle_done = 0; busy = 0.
  - All table entries = DEFAULT_SECS.
- States: IDLE, RUN, HOLD.
- IDLE:
  - start=1 → next edge: phase = 0, remaining = eff(table[0]), prescaler = 0, busy = 1, state = RUN.
  - start is ignored outside IDLE.
- RUN, enable=1:
  - prescaler increments each cycle.
  - On the edge where prescaler == PRESCALE-1: prescaler ← 0.
    - If remaining > 1: remaining ← remaining − 1.
    - If remaining == 1: phase end.
- Phase end (single edge):
  - phase ← (phase == NUM_PHASES-1) ? 0 : phase+1.
  - remaining ← eff(table[next phase]).
  - phase_done = 1 for exactly the following cycle.
  - cycle_done = 1 in the same cycle when wrapping from NUM_PHASES-1 to 0.
  - The sequence repeats indefinitely until stop.
- eff(x) = (x == 0) ? 1 : x. A zero duration is clamped to 1 s; a phase is never skipped.
- Phase length: exactly eff(duration) × PRESCALE cycles of enable=1 in RUN.
- RUN, enable=0 → HOLD: prescaler, remaining and phase frozen.
- HOLD, enable=1 → RUN: counting resumes on that edge with no lost or added cycles.
- stop=1 in RUN or HOLD → next edge: IDLE, busy = 0, phase = 0, remaining = 0, prescaler = 0, no done pulses.
- Priority: reset > stop > tick.
- Table writes:
  - cfg_we writes table[cfg_idx] ← cfg_secs on any edge, in any state.
  - cfg_idx ≥ NUM_PHASES: write ignored.
  - A write to the current phase does not alter `remaining`; it takes effect the next time that phase loads.
  - A write to the next phase on the same edge as a phase end: the new value is NOT used; the old entry loads.
- All outputs are registered. Width arithmetic is unsigned, with no wrap; remaining never goes below 1 while in RUN/HOLD.

Optional Feature:
- Macro PHASE_SKIP_EN.
- Defined: adds input `skip` (1 bit). skip=1 in RUN forces a phase end on the next edge regardless of prescaler/remaining: same advance/reload and phase_done/cycle_done pulses, prescaler ← 0. skip is ignored in IDLE and HOLD; stop has priority over skip.
- Not defined: no `skip` port; phases end only by timeout.

Test Plan:
- Reset then idle: PRESCALE=4, reset 2 cycles → table all 5, phase=0, remaining=0, busy=0; no pulses for 50 cycles without start.
- Basic sequence: PRESCALE=4, NUM_PHASES=4, table {2,3,1,4}, start → phase_done after 8, 12, 4, 16 cycles; cycle_done coincides with the 4th pulse; phase returns to 0 with remaining=2.
- Hold: enable=0 for 10 cycles mid-phase 1 → remaining/phase frozen; phase 1 ends exactly 10 cycles later than in the unpaused run.
- Zero and live-write: table[2]=0 → phase 2 lasts 4 cycles. Write table[1]=7 while in phase 1 → current remaining unchanged; the next visit to phase 1 loads 7.
- Stop/reset mid-run: stop in phase 3 → next cycle IDLE, busy=0, phase=0; start again resumes from phase 0. Reset mid-run → all table entries return to 5.
- PHASE_SKIP_EN: skip pulse in phase 0 with remaining=2 → phase_done next cycle, phase=1, remaining=3; skip in HOLD → no effect.
